// File: rtl/lsu_mem_arbiter.sv
// Arbitrates the LSU's single cache-controller port between speculative loads (LDQ) and
// committed stores (SDQ); one request in flight, load data returned as a ROB writeback.
module lsu_mem_arbiter #(
  parameter int XLEN         = 32,
  parameter int ROB_IDX_W    = 5,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  input  logic                 ldq_issue_vld_i,
  input  logic [XLEN-1:0]      ldq_issue_addr_i,
  input  logic [ROB_IDX_W-1:0] ldq_issue_rob_i,
  output logic                 ldq_issue_en_o,
  input  logic                 sdq_issue_vld_i,
  input  logic [XLEN-1:0]      sdq_issue_addr_i,
  input  logic [XLEN-1:0]      sdq_issue_data_i,
  input  logic                 sdq_full_i,
  output logic                 sdq_issue_en_o,
  output logic                 cc_req_vld_o,
  output logic                 cc_req_wr_rd_o,
  output logic [XLEN-1:0]      cc_req_addr_o,
  output logic [XLEN-1:0]      cc_req_data_o,
  output logic [ROB_IDX_W-1:0] cc_req_rob_o,
  input  logic                 cc_stall_i,
  input  logic                 cc_ld_vld_i,
  input  logic [XLEN-1:0]      cc_ld_data_i,
  output logic                 wb_vld_o,
  output logic [ROB_IDX_W-1:0] wb_rob_o,
  output logic [XLEN-1:0]      wb_data_o,
  output logic                 busy_o
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_LD, DRAIN} state_t;

  state_t                 state_reg, state_next;
  logic [CNT_W-1:0]       starve_cnt_reg, starve_cnt_next;
  logic                   req_wr_reg;
  logic [XLEN-1:0]        req_addr_reg, req_data_reg;
  logic [ROB_IDX_W-1:0]   req_rob_reg;
  logic                   wb_vld_reg, wb_vld_next;
  logic [ROB_IDX_W-1:0]   wb_rob_reg;
  logic [XLEN-1:0]        wb_data_reg;

  logic starved, load_ok, store_win, grant_st, grant_ld, accept;

  // A flushed load is treated as absent, so a pending store can take the slot.
  assign starved   = (starve_cnt_reg == STARVE_MAX);
  assign load_ok   = ldq_issue_vld_i && !flush_i;
  assign store_win = sdq_issue_vld_i && (!load_ok || sdq_full_i || starved);
  assign grant_st  = (state_reg == IDLE) && store_win;
  assign grant_ld  = (state_reg == IDLE) && !store_win && load_ok;

  assign ldq_issue_en_o = grant_ld && rst_ni;
  assign sdq_issue_en_o = grant_st && rst_ni;

  assign cc_req_vld_o   = (state_reg == REQ) && !(flush_i && !req_wr_reg);
  assign accept         = cc_req_vld_o && !cc_stall_i;
  assign cc_req_wr_rd_o = cc_req_vld_o && req_wr_reg;
  assign cc_req_addr_o  = cc_req_vld_o ? req_addr_reg : '0;
  assign cc_req_data_o  = cc_req_vld_o ? req_data_reg : '0;
  assign cc_req_rob_o   = cc_req_vld_o ? req_rob_reg  : '0;

  // A flush coinciding with the writeback pulse kills it.
  assign wb_vld_o  = wb_vld_reg && !flush_i;
  assign wb_rob_o  = wb_vld_o ? wb_rob_reg  : '0;
  assign wb_data_o = wb_vld_o ? wb_data_reg : '0;
  assign busy_o    = (state_reg != IDLE);

  always_comb begin
    state_next      = state_reg;
    starve_cnt_next = starve_cnt_reg;
    wb_vld_next     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (grant_st) begin
          state_next      = REQ;
          starve_cnt_next = '0;
        end else if (grant_ld) begin
          state_next = REQ;
          if (sdq_issue_vld_i && !starved) starve_cnt_next = starve_cnt_reg + CNT_W'(1);
        end
      end
      REQ: begin
        if (!req_wr_reg && flush_i) state_next = IDLE;
        else if (accept)            state_next = req_wr_reg ? IDLE : WAIT_LD;
      end
      WAIT_LD: begin
        if (cc_ld_vld_i) begin
          state_next  = IDLE;
          wb_vld_next = !flush_i;
        end else if (flush_i) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (cc_ld_vld_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg      <= IDLE;
      starve_cnt_reg <= '0;
      req_wr_reg     <= 1'b0;
      req_addr_reg   <= '0;
      req_data_reg   <= '0;
      req_rob_reg    <= '0;
      wb_vld_reg     <= 1'b0;
      wb_rob_reg     <= '0;
      wb_data_reg    <= '0;
    end else begin
      state_reg      <= state_next;
      starve_cnt_reg <= starve_cnt_next;
      wb_vld_reg     <= wb_vld_next;
      if (grant_st) begin
        req_wr_reg   <= 1'b1;
        req_addr_reg <= sdq_issue_addr_i;
        req_data_reg <= sdq_issue_data_i;
        req_rob_reg  <= '0;
      end else if (grant_ld) begin
        req_wr_reg   <= 1'b0;
        req_addr_reg <= ldq_issue_addr_i;
        req_data_reg <= '0;
        req_rob_reg  <= ldq_issue_rob_i;
      end
      if (wb_vld_next) begin
        wb_rob_reg  <= req_rob_reg;
        wb_data_reg <= cc_ld_data_i;
      end
    end
  end

endmodule

// File: tb/tb_lsu_mem_arbiter.sv
// Bench for lsu_mem_arbiter: priority table, directed corner sequences, then random
// traffic against a transaction-level model of the outstanding request.
module tb_lsu_mem_arbiter;
  localparam int XLEN = 32;
  localparam int RW   = 5;
  localparam int LIM  = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic            ldq_vld = 1'b0, sdq_vld = 1'b0, sdq_full = 1'b0;
  logic [XLEN-1:0] ldq_addr = '0, sdq_addr = '0, sdq_data = '0, ld_data = '0;
  logic [RW-1:0]   ldq_rob = '0;
  logic            cc_stall = 1'b0, cc_ld_vld = 1'b0;
  logic            ldq_en, sdq_en, req_vld, req_wr, wb_vld, busy;
  logic [XLEN-1:0] req_addr, req_data, wb_data;
  logic [RW-1:0]   req_rob, wb_rob;

  wire [111:0] all_out = {ldq_en, sdq_en, req_vld, req_wr, req_addr, req_data, req_rob,
                          wb_vld, wb_rob, wb_data, busy};

  always #5 clk = ~clk;

  lsu_mem_arbiter #(.XLEN(XLEN), .ROB_IDX_W(RW), .STARVE_LIMIT(LIM)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .ldq_issue_vld_i(ldq_vld), .ldq_issue_addr_i(ldq_addr), .ldq_issue_rob_i(ldq_rob),
    .ldq_issue_en_o(ldq_en),
    .sdq_issue_vld_i(sdq_vld), .sdq_issue_addr_i(sdq_addr), .sdq_issue_data_i(sdq_data),
    .sdq_full_i(sdq_full), .sdq_issue_en_o(sdq_en),
    .cc_req_vld_o(req_vld), .cc_req_wr_rd_o(req_wr), .cc_req_addr_o(req_addr),
    .cc_req_data_o(req_data), .cc_req_rob_o(req_rob), .cc_stall_i(cc_stall),
    .cc_ld_vld_i(cc_ld_vld), .cc_ld_data_i(ld_data),
    .wb_vld_o(wb_vld), .wb_rob_o(wb_rob), .wb_data_o(wb_data), .busy_o(busy)
  );

  int tests = 0;
  int fails = 0;

  // Model: one outstanding transaction record plus a pending writeback.
  bit              o_vld, o_st, o_acc, o_kill, wb_pend;
  logic [XLEN-1:0] o_addr, o_dat, wb_dat;
  logic [RW-1:0]   o_rob, wb_exp_rob;
  int              starve;

  // Payload used by the next step().
  logic [XLEN-1:0] p_lad, p_sad, p_sdat, p_ldat;
  logic [RW-1:0]   p_lrob;

  typedef struct {
    bit ld, sd, full, fl;
    logic [1:0] exp_en;  // {ldq_en, sdq_en}
  } vec_t;
  vec_t vecs[8];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    o_vld = 0; o_st = 0; o_acc = 0; o_kill = 0; wb_pend = 0; starve = 0;
  endtask

  task automatic step(input bit ld, input bit sd, input bit full, input bit fl,
                      input bit stall, input bit ldv);
    bit idle, ld_ok, st_win, ld_win, e_req, e_wb;
    @(negedge clk);
    ldq_vld = ld; sdq_vld = sd; sdq_full = full; flush = fl; cc_stall = stall; cc_ld_vld = ldv;
    ldq_addr = p_lad; ldq_rob = p_lrob; sdq_addr = p_sad; sdq_data = p_sdat; ld_data = p_ldat;
    #1;
    idle   = !o_vld;
    ld_ok  = ld && !fl;
    st_win = idle && sd && (!ld_ok || full || starve == LIM);
    ld_win = idle && !st_win && ld_ok;
    e_req  = o_vld && !o_acc && !(fl && !o_st);
    e_wb   = wb_pend && !fl;
    chk("ldq_en", ldq_en, ld_win);
    chk("sdq_en", sdq_en, st_win);
    chk("req_vld", req_vld, e_req);
    if (e_req) chk("req_fields", {req_wr, req_addr, req_data, req_rob}, {o_st, o_addr, o_dat, o_rob});
    chk("wb_vld", wb_vld, e_wb);
    if (e_wb) chk("wb_fields", {wb_rob, wb_data}, {wb_exp_rob, wb_dat});
    chk("busy", busy, o_vld);
    wb_pend = 0;
    if (o_vld) begin
      if (!o_acc) begin
        if (e_req && !stall) begin
          if (o_st) o_vld = 0; else o_acc = 1;
        end else if (fl && !o_st) begin
          o_vld = 0;
        end
      end else if (ldv) begin
        o_vld = 0;
        if (!o_kill && !fl) begin wb_pend = 1; wb_exp_rob = o_rob; wb_dat = p_ldat; end
      end else if (fl) begin
        o_kill = 1;
      end
    end else if (st_win) begin
      o_vld = 1; o_st = 1; o_acc = 0; o_kill = 0;
      o_addr = p_sad; o_dat = p_sdat; o_rob = '0; starve = 0;
    end else if (ld_win) begin
      o_vld = 1; o_st = 0; o_acc = 0; o_kill = 0;
      o_addr = p_lad; o_dat = '0; o_rob = p_lrob;
      if (sd && starve < LIM) starve++;
    end
  endtask

  initial begin
    model_reset();
    p_lad = '0; p_sad = '0; p_sdat = '0; p_ldat = '0; p_lrob = '0;
    vecs = '{'{1'b0, 1'b0, 1'b0, 1'b0, 2'b00}, '{1'b1, 1'b0, 1'b0, 1'b0, 2'b10},
             '{1'b0, 1'b1, 1'b0, 1'b0, 2'b01}, '{1'b1, 1'b1, 1'b0, 1'b0, 2'b10},
             '{1'b1, 1'b1, 1'b1, 1'b0, 2'b01}, '{1'b1, 1'b0, 1'b0, 1'b1, 2'b00},
             '{1'b1, 1'b1, 1'b0, 1'b1, 2'b01}, '{1'b0, 1'b1, 1'b1, 1'b0, 2'b01}};

    #1 chk("reset_outputs", all_out, 112'd0);
    @(negedge clk) rst_n = 1'b1;

    // Grant priority in IDLE; inputs drop before the edge so no grant is taken.
    foreach (vecs[i]) begin
      @(negedge clk);
      ldq_vld = vecs[i].ld; sdq_vld = vecs[i].sd; sdq_full = vecs[i].full; flush = vecs[i].fl;
      #1 chk($sformatf("prio_vec%0d", i), {ldq_en, sdq_en}, vecs[i].exp_en);
      #2 ldq_vld = 0; sdq_vld = 0; sdq_full = 0; flush = 0;
    end

    // Single load, data back two cycles after accept.
    p_lad = 32'h100; p_lrob = 5'd3; p_ldat = 32'hDEADBEEF;
    step(1, 0, 0, 0, 0, 0);
    chk("t1_grant", ldq_en, 1'b1);
    step(0, 0, 0, 0, 0, 0);
    chk("t1_req", {req_vld, req_wr, req_addr, req_rob}, {1'b1, 1'b0, 32'h100, 5'd3});
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0);
    chk("t1_wb", {wb_vld, wb_rob, wb_data}, {1'b1, 5'd3, 32'hDEADBEEF});

    // Starvation: LIM loads then the store is forced, counter cleared afterwards.
    p_sad = 32'h200; p_sdat = 32'h5555AAAA;
    for (int i = 0; i <= LIM; i++) begin
      step(1, 1, 0, 0, 0, 0);
      chk($sformatf("t2_grant%0d", i), {ldq_en, sdq_en}, (i < LIM) ? 2'b10 : 2'b01);
      step(0, 0, 0, 0, 0, 0);
      if (i < LIM) step(0, 0, 0, 0, 0, 1);
    end
    step(1, 1, 0, 0, 0, 0);
    chk("t2_cnt_cleared", {ldq_en, sdq_en}, 2'b10);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);

    // SDQ full forces the store first.
    p_sdat = 32'hCAFEF00D;
    step(1, 1, 1, 0, 0, 0);
    chk("t3_grant", {ldq_en, sdq_en}, 2'b01);
    step(0, 0, 0, 0, 0, 0);
    chk("t3_req", {req_vld, req_wr, req_data, req_rob}, {1'b1, 1'b1, 32'hCAFEF00D, 5'd0});
    step(0, 0, 0, 0, 0, 0);
    chk("t3_idle", busy, 1'b0);

    // Stalled store survives a flush and is accepted on the fourth REQ cycle.
    p_sad = 32'h340; p_sdat = 32'h01234567;
    step(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, (i == 1), 1, 0);
      chk($sformatf("t4_hold%0d", i), {req_vld, req_addr, req_data}, {1'b1, 32'h340, 32'h01234567});
    end
    step(0, 0, 0, 0, 0, 0);
    chk("t4_accept", req_vld, 1'b1);
    step(0, 0, 0, 0, 0, 0);
    chk("t4_idle", busy, 1'b0);

    // Flush while waiting for load data: drain, no writeback.
    p_lad = 32'h480; p_lrob = 5'd9; p_ldat = 32'h77777777;
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("t5_drain_busy", busy, 1'b1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0);
    chk("t5_no_wb", {wb_vld, busy}, 2'b00);

    // Saturate the counter, then reset asynchronously in the middle of a load REQ.
    for (int i = 0; i < LIM; i++) begin
      step(1, 1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 1);
    end
    step(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    ldq_vld = 1; sdq_vld = 1; cc_stall = 1; flush = 0; cc_ld_vld = 0;
    #1 chk("t6_in_req", req_vld, 1'b1);
    #1 rst_n = 1'b0;
    #1 chk("t6_reset_outputs", all_out, 112'd0);
    @(negedge clk);
    ldq_vld = 0; sdq_vld = 0; cc_stall = 0;
    rst_n = 1'b1;
    model_reset();
    step(1, 1, 0, 0, 0, 0);
    chk("t6_cnt_cleared", {ldq_en, sdq_en}, 2'b10);

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      p_lad = $urandom; p_sad = $urandom; p_sdat = $urandom; p_ldat = $urandom;
      p_lrob = RW'($urandom);
      step($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 5, $urandom_range(0, 9) == 0,
           $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 3,
           o_vld && o_acc && ($urandom_range(0, 9) < 4));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
